// File: rtl/wb_ram128_rmw_ctrl.sv
// wb_ram128_rmw_ctrl
//
// Wishbone-classic slave in front of the 128x32 scratch SRAM wrapper. The
// wrapper only commits a write when all four byte enables are set, so any
// partial-byte write is turned into a read-modify-write (RD, RDW, WR).
// All outputs are registered; the acknowledge is additionally gated by
// wbs_cyc_i so an abandoned cycle never sees an ack.
//
// Ports:
//   wb_clk_i, wb_rst_i  clock and asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i  Wishbone slave request
//   wbs_ack_o, wbs_dat_o                    Wishbone slave response
//   ram_en0, ram_we0, ram_a0, ram_di0        SRAM port (we is 4'hF or 4'h0)
//   ram_do0                                  SRAM read data, one cycle after read
module wb_ram128_rmw_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WSIZE     = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ram_en0,
  output logic [3:0]  ram_we0,
  output logic [6:0]  ram_a0,
  output logic [31:0] ram_di0,
  input  logic [31:0] ram_do0
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, ACK} state_t;

  state_t      state_q, state_d;
  logic [6:0]  capIdx_q, capIdx_d;
  logic [3:0]  capSel_q, capSel_d;
  logic        capWe_q, capWe_d;
  logic [31:0] capDat_q, capDat_d;
  logic        ack_q, ack_d;
  logic [31:0] datOut_q, datOut_d;
  logic        ramEn_q, ramEn_d;
  logic [3:0]  ramWe_q, ramWe_d;
  logic [6:0]  ramAddr_q, ramAddr_d;
  logic [31:0] ramData_q, ramData_d;

  logic        hit;
  logic [31:0] merged;
  logic        unusedAdrBits;

  // Byte-lane bits of the address carry no meaning for a word-wide RAM.
  assign unusedAdrBits = ^wbs_adr_i[1:0];

  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:9] == BASE_ADDR[31:9]);

  // Merge the captured write bytes over the word just read from the RAM.
  always_comb begin
    merged = ram_do0;
    for (int i = 0; i < WSIZE; i++) begin
      if (capSel_q[i]) merged[8*i +: 8] = capDat_q[8*i +: 8];
    end
  end

  // Next-state logic. Output registers are loaded with the values that the
  // state being entered must present, which keeps every output registered.
  always_comb begin
    state_d   = state_q;
    capIdx_d  = capIdx_q;
    capSel_d  = capSel_q;
    capWe_d   = capWe_q;
    capDat_d  = capDat_q;
    ack_d     = 1'b0;
    datOut_d  = datOut_q;
    ramEn_d   = 1'b0;
    ramWe_d   = 4'h0;
    ramAddr_d = ramAddr_q;
    ramData_d = ramData_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          capIdx_d = wbs_adr_i[8:2];
          capSel_d = wbs_sel_i;
          capWe_d  = wbs_we_i;
          capDat_d = wbs_dat_i;
          if (wbs_we_i && wbs_sel_i == 4'hF) begin
            state_d   = WR;
            ramEn_d   = 1'b1;
            ramWe_d   = 4'hF;
            ramAddr_d = wbs_adr_i[8:2];
            ramData_d = wbs_dat_i;
          end else if (wbs_we_i && wbs_sel_i == 4'h0) begin
            // Nothing to write: acknowledge without touching the RAM.
            state_d = ACK;
            ack_d   = 1'b1;
          end else begin
            state_d   = RD;
            ramEn_d   = 1'b1;
            ramAddr_d = wbs_adr_i[8:2];
          end
        end
      end
      RD: begin
        state_d = RDW;
      end
      RDW: begin
        if (capWe_q) begin
          state_d   = WR;
          ramEn_d   = 1'b1;
          ramWe_d   = 4'hF;
          ramAddr_d = capIdx_q;
          ramData_d = merged;
        end else begin
          state_d  = ACK;
          ack_d    = 1'b1;
          datOut_d = ram_do0;
        end
      end
      WR: begin
        state_d = ACK;
        ack_d   = 1'b1;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      capIdx_q  <= '0;
      capSel_q  <= '0;
      capWe_q   <= 1'b0;
      capDat_q  <= '0;
      ack_q     <= 1'b0;
      datOut_q  <= '0;
      ramEn_q   <= 1'b0;
      ramWe_q   <= '0;
      ramAddr_q <= '0;
      ramData_q <= '0;
    end else begin
      state_q   <= state_d;
      capIdx_q  <= capIdx_d;
      capSel_q  <= capSel_d;
      capWe_q   <= capWe_d;
      capDat_q  <= capDat_d;
      ack_q     <= ack_d;
      datOut_q  <= datOut_d;
      ramEn_q   <= ramEn_d;
      ramWe_q   <= ramWe_d;
      ramAddr_q <= ramAddr_d;
      ramData_q <= ramData_d;
    end
  end

  // A dropped cycle still lets the RAM sequence finish but hides the ack.
  assign wbs_ack_o = ack_q & wbs_cyc_i;
  assign wbs_dat_o = datOut_q;
  assign ram_en0   = ramEn_q;
  assign ram_we0   = ramWe_q;
  assign ram_a0    = ramAddr_q;
  assign ram_di0   = ramData_q;

endmodule

// File: doc/wb_ram128_rmw_ctrl.md
Name: wb_ram128_rmw_ctrl

Overview:
- Wishbone-classic slave that owns the 128x32 word scratch SRAM macro wrapper and drives its single read/write port.
- The SRAM wrapper commits a write only when all four byte enables are set. This block therefore turns every partial-byte Wishbone write into a read-modify-write sequence.
- Sits directly upstream of the SRAM wrapper, between the user-project Wishbone bus and the RAM port.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base address; the block responds when wbs_adr_i[31:9] == BASE_ADDR[31:9].
- WSIZE, 4, bytes per word; fixed at 4, with no other value supported.

Ports:
- wb_clk_i  in  1  single clock; all state changes on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address; word index = wbs_adr_i[8:2].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid while ack is high.
- ram_en0  out  1  SRAM port enable.
- ram_we0  out  4  SRAM write enables; always 4'hF or 4'h0.
- ram_a0  out  7  SRAM word address.
- ram_di0  out  32  SRAM write data.
- ram_do0  in  32  SRAM read data, valid the cycle after an enabled read edge.

Behaviour:
- Reset (asynchronous, wb_rst_i=1): state=IDLE; wbs_ack_o=0, wbs_dat_o=0, ram_en0=0, ram_we0=0, ram_a0=0, ram_di0=0. Reset mid-operation abandons the transaction immediately; no ack is issued and no further RAM access occurs.
- All outputs are registered. The only exception is the ack gating described under "Abort".
- Hit condition: wbs_cyc_i & wbs_stb_i & address match.
- Capture: in IDLE, a hit at edge E0 captures adr[8:2], sel, we and dat. Inputs are ignored outside IDLE.
- States: IDLE, RD, RDW, WR, ACK.
- Transitions at edge E0 out of IDLE:
  - we=1, sel=4'hF -> WR.
  - we=1, sel=4'h0 -> ACK; no RAM access.
  - we=1, any other sel -> RD (RMW).
  - we=0 -> RD.
- RD: ram_en0=1, ram_we0=0, ram_a0=captured index. Next state RDW.
- RDW: ram_en0=0. At the end of the cycle, ram_do0 is captured.
  - Read: wbs_dat_o <= ram_do0, next state ACK.
  - RMW: build merged word, where byte i = sel[i] ? dat_i byte i : ram_do0 byte i. Load it into ram_di0; next state WR.
- WR: ram_en0=1, ram_we0=4'hF, ram_a0=captured index, ram_di0=full data or merged word. Next state ACK.
- ACK: ack register = 1 for exactly one cycle, then IDLE. No request is accepted in the ACK cycle.
- Ack timing (rising edge after capture edge E0):
  - sel=0 write: E0.
  - Full write: E0+1.
  - Read: E0+2.
  - Partial write: E0+3.
- wbs_dat_o:
  - Holds the last read value until the next read capture.
  - Unchanged by writes.
  - Zero after reset.
- Abort: if wbs_cyc_i drops mid-transaction, the RAM sequence still completes, including the WR of an RMW, so the memory never sees half an update. wbs_ack_o = ack register & wbs_cyc_i, so no ack is presented to a dead cycle.
- Out of range: a miss is ignored and never acked. The bus default-slave timeout handles it.
- Ordering: a read issued back-to-back after a write to the same word returns the written data. This holds because WR always completes before IDLE.
- Index wrap: 7-bit index. Byte address BASE+0x1FC maps to index 127; BASE+0x200 is a miss.

Test Plan:
- Full write then read: write 0xDEADBEEF to BASE+0x10 with sel=F. Expect ack at E0+1, one WR cycle with ram_a0=4, ram_we0=F. Then read BASE+0x10: ack at E0+2, wbs_dat_o=0xDEADBEEF.
- Partial RMW: preload 0x11223344 at index 5. Write 0xAABBCCDD with sel=4'b0101. Expect RD, RDW, WR sequence with ram_di0=0x11BB33DD and ack at E0+3. A subsequent read returns 0x11BB33DD.
- Zero-sel write: sel=0 write to index 9. Expect ack at E0, ram_en0 never asserted, and memory contents unchanged on readback.
- Address bounds: an access to BASE+0x1FC hits index 127 and acks. An access to BASE+0x200 produces no ack and no ram_en0 for 10 cycles.
- Abort: drop wbs_cyc_i during RDW of a partial write. WR still occurs with the merged data, and wbs_ack_o stays 0.
- Reset mid-RMW: assert wb_rst_i during RDW. All outputs go to 0 asynchronously, no WR follows, and the original word is intact on readback after reset release.
